agg_bus_arbiter: RTL

//   N-master to 1-slave arbiter for the aggregate valid/addr/wdata -> rdata/ready bus.

---
 rtl/agg_bus_pkg.sv | 17 +
 rtl/agg_bus_arbiter_if.sv | 25 ++
 rtl/agg_rr_picker.sv | 27 ++
 rtl/agg_bus_arbiter.sv | 125 ++++++++++++
 4 files changed

// File: rtl/agg_bus_pkg.sv
// Shared types and constants for the N-master aggregate bus arbiter.
package agg_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RESP  = 2'd2
    } agg_state_e;

    localparam int AGG_MAX_W = 64;

    // Response data returned to the master when the slave hangs; callers truncate.
    function automatic logic [AGG_MAX_W-1:0] AGG_RD_ERR();
        return '1;
    endfunction

endpackage

// File: rtl/agg_bus_arbiter_if.sv
// Aggregate valid/addr/wdata -> rdata/ready bus, master lanes packed [lane][bit].
interface agg_bus_arbiter_if #(
    parameter int N_MST  = 2,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
);
    logic [N_MST-1:0]             mst_valid;
    logic [N_MST-1:0][ADDR_W-1:0] mst_addr;
    logic [N_MST-1:0][DATA_W-1:0] mst_wdata;
    logic [N_MST-1:0][DATA_W-1:0] mst_rdata;
    logic [N_MST-1:0]             mst_ready;

    logic                         slv_valid;
    logic [ADDR_W-1:0]            slv_addr;
    logic [DATA_W-1:0]            slv_wdata;
    logic [DATA_W-1:0]            slv_rdata;
    logic                         slv_ready;

    modport master (output mst_valid, mst_addr, mst_wdata, input mst_rdata, mst_ready);
    modport slave  (input slv_valid, slv_addr, slv_wdata, output slv_rdata, slv_ready);
    modport arb (
        input  mst_valid, mst_addr, mst_wdata, slv_rdata, slv_ready,
        output mst_rdata, mst_ready, slv_valid, slv_addr, slv_wdata
    );
endinterface

// File: rtl/agg_rr_picker.sv
// Combinational round-robin priority: first set request at or above ptr, wrapping.
module agg_rr_picker #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          any
);
    logic [IW-1:0] j;

    // Scan from the farthest offset down so the nearest hit above ptr wins last.
    always_comb begin
        idx = '0;
        any = 1'b0;
        j   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = IW'((int'(ptr) + k) % N);
            if (req[j]) begin
                idx = j;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/agg_bus_arbiter.sv
// N-master to 1-slave round-robin arbiter, one transaction in flight, registered outputs.
// Optional slave-hang abort enabled by defining AGG_ARB_TIMEOUT_EN.
module agg_bus_arbiter
    import agg_bus_pkg::*;
#(
    parameter int N_MST       = 2,
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 4,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                     clock,
    input  logic                     reset,
    agg_bus_arbiter_if.arb           bus,
    output logic [$clog2(N_MST)-1:0] grant_id,
    output logic                     busy,
    output logic                     err
);
    localparam int IW = $clog2(N_MST);

    agg_state_e        state;
    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     win;
    logic              any;
    logic              vld_q;
    logic [N_MST-1:0]  ready_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

`ifdef AGG_ARB_TIMEOUT_EN
    localparam int                CW     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [DATA_W-1:0] RD_ERR = DATA_W'(AGG_RD_ERR());
    logic [CW-1:0] tmo_cnt;
    logic          err_q;
    assign err = err_q;
`else
    localparam int unused_tmo = TIMEOUT_CYC;
    assign err = 1'b0;
`endif

    agg_rr_picker #(.N(N_MST), .IW(IW)) u_pick (
        .req (bus.mst_valid),
        .ptr (rr_ptr),
        .idx (win),
        .any (any)
    );

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (i == IW'(N_MST - 1)) ? '0 : i + 1'b1;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            vld_q    <= 1'b0;
            ready_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            busy     <= 1'b0;
`ifdef AGG_ARB_TIMEOUT_EN
            tmo_cnt  <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            ready_q <= '0;
`ifdef AGG_ARB_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    // Request fields are captured once; masters may change them afterwards.
                    if (any) begin
                        addr_q   <= bus.mst_addr[win];
                        wdata_q  <= bus.mst_wdata[win];
                        grant_id <= win;
                        vld_q    <= 1'b1;
                        busy     <= 1'b1;
                        state    <= GRANT;
`ifdef AGG_ARB_TIMEOUT_EN
                        tmo_cnt  <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (bus.slv_ready) begin
                        rdata_q           <= bus.slv_rdata;
                        vld_q             <= 1'b0;
                        ready_q[grant_id] <= 1'b1;
                        state             <= RESP;
                    end
`ifdef AGG_ARB_TIMEOUT_EN
                    else if (tmo_cnt == CW'(TIMEOUT_CYC - 1)) begin
                        rdata_q           <= RD_ERR;
                        vld_q             <= 1'b0;
                        ready_q[grant_id] <= 1'b1;
                        err_q             <= 1'b1;
                        state             <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    busy   <= 1'b0;
                    rr_ptr <= next_idx(grant_id);
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.slv_valid = vld_q;
    assign bus.slv_addr  = addr_q;
    assign bus.slv_wdata = wdata_q;
    assign bus.mst_ready = ready_q;

    for (genvar i = 0; i < N_MST; i++) begin : g_lane
        assign bus.mst_rdata[i] = rdata_q;
    end

endmodule
